// File: rtl/pio_pkg.sv
// pio_pkg: shared encodings and field positions for the PIO execution stage
package pio_pkg;
  localparam int OP_LSB  = 13;
  localparam int DLY_LSB = 8;
  localparam int ARG_LSB = 5;
  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SET  = 3'b111;
  localparam logic [2:0] C_ALWAYS = 3'd0;
  localparam logic [2:0] C_XZ     = 3'd1;
  localparam logic [2:0] C_XDEC   = 3'd2;
  localparam logic [2:0] C_YZ     = 3'd3;
  localparam logic [2:0] C_YDEC   = 3'd4;
  localparam logic [2:0] C_XNEY   = 3'd5;
  localparam logic [2:0] C_PIN    = 3'd6;
  localparam logic [2:0] D_PINS    = 3'd0;
  localparam logic [2:0] D_X       = 3'd1;
  localparam logic [2:0] D_Y       = 3'd2;
  localparam logic [2:0] D_PINDIRS = 3'd4;
  localparam logic [2:0] S_GPIO = 3'd0;
  localparam logic [2:0] S_X    = 3'd1;
  localparam logic [2:0] S_Y    = 3'd2;
  localparam logic [2:0] S_NULL = 3'd3;
  localparam logic [1:0] MOP_INV = 2'b01;
  localparam logic [1:0] W_GPIO  = 2'b00;
  typedef enum logic {EXEC, DELAY} state_t;
endpackage

// File: rtl/pio_jmp_cond.sv
// pio_jmp_cond: evaluates a JMP condition against pre-decrement X/Y and the jump pin
module pio_jmp_cond
  import pio_pkg::*;
(
  input  logic [2:0]  cond,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        pin,
  output logic        taken
);
  always_comb
    case (cond)
      C_ALWAYS: taken = 1'b1;
      C_XZ:     taken = x == '0;
      C_XDEC:   taken = x != '0;
      C_YZ:     taken = y == '0;
      C_YDEC:   taken = y != '0;
      C_XNEY:   taken = x != y;
      C_PIN:    taken = pin;
      default:  taken = 1'b0;
    endcase
endmodule

// File: rtl/pio_exec_unit.sv
// pio_exec_unit: executes one PIO instruction per cycle with WAIT stalls and delay cycles
module pio_exec_unit
  import pio_pkg::*;
#(
  parameter int JMP_PIN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sm_en,
  input  logic [15:0] instr,
  input  logic [31:0] gpio_in,
  output logic        pc_en,
  output logic        jump_en,
  output logic [3:0]  jump,
  output logic [4:0]  set_pins,
  output logic [4:0]  set_pindirs,
  output logic [31:0] x_out,
  output logic [31:0] y_out
);
  state_t state, state_nx;
  logic [4:0] dcnt, delay, pins_nx, dirs_nx;
  logic [2:0] op, arg, src;
  logic [3:0] lat_target, strobe_target;
  logic [31:0] mov_src, mov_val, x_nx, y_nx;
  logic lat_taken, cond_taken, taken, wait_ok, commit, strobe, strobe_taken, mov_ok, set_op;
  assign op = instr[OP_LSB +: 3];
  assign delay = instr[DLY_LSB +: 5];
  assign arg = instr[ARG_LSB +: 3];
  assign src = instr[2:0];
  pio_jmp_cond u_cond (
    .cond (arg),
    .x    (x_out),
    .y    (y_out),
    .pin  (gpio_in[JMP_PIN]),
    .taken(cond_taken)
  );
  assign taken = op == OP_JMP && cond_taken;
  assign wait_ok = !(op == OP_WAIT && instr[6:5] == W_GPIO && gpio_in[instr[4:0]] != instr[7]);
  assign commit = state == EXEC && wait_ok;
  always_comb begin
    strobe = commit ? delay == '0 : state == DELAY && dcnt == 5'd1;
    strobe_taken = commit ? taken : lat_taken;
    strobe_target = commit ? instr[3:0] : lat_target;
    state_nx = commit && delay != '0 ? DELAY : strobe ? EXEC : state;
  end
  // strobes are suppressed while frozen or in reset so the program counter never moves
  assign pc_en = sm_en && !rst && strobe && !strobe_taken;
  assign jump_en = sm_en && !rst && strobe && strobe_taken;
  assign jump = jump_en ? strobe_target : '0;
  always_comb begin
    set_op = op == OP_SET;
    mov_ok = op == OP_MOV && src <= S_NULL;
    mov_src = src == S_GPIO ? gpio_in : src == S_X ? x_out : src == S_Y ? y_out : '0;
    mov_val = instr[4:3] == MOP_INV ? ~mov_src : mov_src;
    x_nx = op == OP_JMP && arg == C_XDEC ? x_out - 32'd1 :
           mov_ok && arg == D_X ? mov_val :
           set_op && arg == D_X ? {27'd0, instr[4:0]} : x_out;
    y_nx = op == OP_JMP && arg == C_YDEC ? y_out - 32'd1 :
           mov_ok && arg == D_Y ? mov_val :
           set_op && arg == D_Y ? {27'd0, instr[4:0]} : y_out;
    pins_nx = mov_ok && arg == D_PINS ? mov_val[4:0] :
              set_op && arg == D_PINS ? instr[4:0] : set_pins;
    dirs_nx = set_op && arg == D_PINDIRS ? instr[4:0] : set_pindirs;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= EXEC;
      dcnt <= '0;
      lat_taken <= 1'b0;
      lat_target <= '0;
      x_out <= '0;
      y_out <= '0;
      set_pins <= '0;
      set_pindirs <= '0;
    end else if (sm_en) begin
      state <= state_nx;
      dcnt <= commit ? delay : state == DELAY ? dcnt - 5'd1 : dcnt;
      if (commit) begin
        lat_taken <= taken;
        lat_target <= instr[3:0];
        x_out <= x_nx;
        y_out <= y_nx;
        set_pins <= pins_nx;
        set_pindirs <= dirs_nx;
      end
    end
endmodule

// File: doc/pio_exec_unit.md
# pio_exec_unit

Execution stage of the PIO state machine: consumes the 16-bit instruction read from `instruction_regfile` at the current `pc` and executes it. It drives `pc_en`/`jump`/`jump_en` back into `program_counter`. It owns the X/Y scratch registers, the SET/MOV pin outputs, WAIT stalls and per-instruction delay cycles. It executes one instruction per cycle, plus any stall and delay cycles.

## Interface
- `JMP_PIN`, default 0: `gpio_in` bit tested by JMP condition PIN.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sm_en`  in  1  execution enable; 0 freezes all state, `pc_en`=`jump_en`=0.
- `instr`  in  16  instruction at current `pc` (regfile `data_out`, valid combinationally same cycle).
- `gpio_in`  in  32  input pin levels.
- `pc_en`  out  1  advance `pc` by one (wrap handled by `program_counter`).
- `jump_en`  out  1  load `jump` into `pc`; never asserted together with `pc_en`.
- `jump`  out  4  jump target.
- `set_pins`  out  5  pin output values.
- `set_pindirs`  out  5  pin direction values.
- `x_out`, `y_out`  out  32 each  X/Y scratch registers (observability).

## Operation
- Encoding: opcode `[15:13]`, delay `[12:8]` (all 5 bits delay, no side-set), operands `[7:0]`.
- JMP (000): cond `[7:5]`, target `instr[3:0]`, bit 4 ignored.
  - 000 always; 001 X==0; 010 X!=0 then X--; 011 Y==0; 100 Y!=0 then Y--.
  - 101 X!=Y; 110 `gpio_in[JMP_PIN]`==1; 111 never taken.
  - X--/Y-- decrement unconditionally, testing the pre-decrement value. Decrement is 32-bit and wraps 0 to 0xFFFFFFFF.
- WAIT (001): polarity `[7]`, source `[6:5]`, index `[4:0]`.
  - Source 00 (GPIO): stall while `gpio_in[index]`!=polarity.
  - Other sources: NOP.
  - Delay counts only after the condition is met.
- MOV (101): dest `[7:5]` (000 PINS, 001 X, 010 Y), op `[4:3]` (00 none, 01 bitwise invert), src `[2:0]` (000 `gpio_in`, 001 X, 010 Y, 011 zero).
  - Invalid dest or src: NOP.
  - PINS dest takes the low 5 bits.
- SET (111): dest `[7:5]` (000 PINS, 001 X, 010 Y, 100 PINDIRS), data `[4:0]`.
  - X/Y are zero-extended.
  - Other dest values: NOP.
- IN/OUT/PUSH/PULL/IRQ (010, 011, 100, 110): NOP, with delay still honoured.
- FSM, states EXEC and DELAY:
  - EXEC, WAIT not satisfied: stay, no pc strobe, no side effects.
  - EXEC, otherwise: commit side effects this edge.
    - delay==0: strobe `pc_en` or `jump_en`.
    - delay d>0: latch taken flag and target, load `dcnt`=d, go to DELAY, no strobe.
  - DELAY: `dcnt` decrements each cycle. When `dcnt`==1, strobe the latched `jump_en`/`pc_en` and return to EXEC.
- `pc_en`, `jump_en`, `jump` are combinational from `instr`, state and registers. `jump` is 0 whenever `jump_en`=0.
- Reset values: X=0, Y=0, `set_pins`=0, `set_pindirs`=0, state EXEC, `dcnt`=0. `pc_en`/`jump_en`/`jump` are forced 0 while `rst`=1.
- `rst` mid-delay or mid-stall: abandon the instruction; latched jump is discarded.
- `sm_en`=0 mid-delay: hold `dcnt`, resume exactly when re-enabled.

## Timing
- Instruction with delay d and no stall occupies 1+d cycles. The pc strobe is in the last cycle, so the next instruction is presented the cycle after.
- Side effects (X, Y, pins, pindirs) are visible on outputs the cycle after the EXEC cycle.
- WAIT satisfied in cycle n: pc strobe in cycle n+d.
- Jump condition uses register values at the start of the EXEC cycle.

## Structure
- Shared package `pio_pkg`:
  - opcode, JMP condition, MOV/SET dest/src constants;
  - state encoding;
  - field position localparams.
- Sub-module `pio_jmp_cond`: combinational condition evaluator (cond, X, Y, pin → taken).
- Everything else lives in `pio_exec_unit`.
- Upper-level wrapper connects `program_counter.pc` → `instruction_regfile.read_addr` and `data_out` → `instr`.

## Test plan
- Reset, then program `SET X,5` (0xE025), `JMP X--,1` (0x0041) at addr 0/1 → `jump_en` with `jump`=1 five times (X=5..1), then `pc_en` when X=0; final X=0xFFFFFFFF.
- `SET PINS,0x1F` with delay 3 (0xE31F) → `set_pins`=0x1F after cycle 1; `pc_en` only in cycle 4.
- `WAIT 1 GPIO 7` (0x2087), `gpio_in[7]`=0 for 10 cycles then 1 → no strobe for 10 cycles, `pc_en` the cycle `gpio_in[7]`=1.
- `MOV X,~NULL` (0xA02B) then `JMP X!=Y,0` with Y=0 (0x00A0) → X=0xFFFFFFFF, `jump_en`=1, `jump`=0.
- `JMP 5` with delay 4 (0x0405), `rst` in 2nd DELAY cycle → no `jump_en`, state EXEC, X/Y/pins 0.
- `sm_en` dropped for 3 cycles mid-delay → strobe slips by exactly 3 cycles.
